sevenseg_scanner: RTL and testbench
===================================

// Module: sevenseg_scanner
// PURPOSE
//  Time-multiplexes 8 hex/BCD digits onto the Nexys 8-digit common-anode 7-segment display.
//  Sits directly downstream of the stopwatch; consumes its display/digit_enable/dp_enable and drives board pins.
//  Snapshots inputs once per scan frame so a frame never shows mixed old/new digits (no tearing).
// PARAMETERS
//  FREQ_HZ      100000000  clk frequency in Hz
//  DIGIT_HZ     800        per-digit slot rate in Hz; frame rate = DIGIT_HZ/8
//  BLANK_TICKS  16         anti-ghost blanking cycles at the start of each slot; must be < SLOT_TICKS
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  display       in   32  8 digits, 4 bits each; digit i = display[i*4+:4]; digit 0 = rightmost
//  digit_enable  in   8   1 = digit i lit
//  dp_enable     in   8   1 = decimal point i lit
//  brightness    in   3   dimming level 0..7; used only with SEVENSEG_DIM_EN
//  anode         out  8   active-low anode select; anode[i] drives digit i
//  seg           out  7   active-low cathodes {g,f,e,d,c,b,a}
//  dp            out  1   active-low decimal-point cathode
//  frame_start   out  1   one-cycle strobe on the cycle the snapshot registers load
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All outputs are registered.
//  - Reset values: anode=8'hFF, seg=7'h7F, dp=1, frame_start=0, slot timer=0, index=0.
//    Snapshot registers are all 0; load_pending=1.
//  - SLOT_TICKS = FREQ_HZ/DIGIT_HZ - 1. The slot timer counts 0..SLOT_TICKS, then wraps to 0.
//    On each wrap, index increments mod 8 (7 -> 0).
//  - Snapshot load: display, digit_enable and dp_enable are copied to frame regs when
//    (a) the timer wraps while index==7, or (b) load_pending==1 (first cycle after reset).
//    The load clears load_pending. frame_start pulses on the same edge as the load.
//    Inputs changing mid-frame have no effect until the next load.
//  - Output drive, registered one cycle after the timer/index state:
//      timer < BLANK_TICKS                    -> anode=8'hFF, seg=7'h7F, dp=1
//      else if frame_en[index]==0             -> same all-off pattern
//      else                                   -> anode = ~(8'b1<<index), seg = hex7(frame_digit[index]),
//                                                dp = ~frame_dp[index]
//  - hex7 decodes all 16 codes 0-F (A,b,C,d,E,F for 10-15). Nibbles 10-15 are never blanked.
//  - dp_enable with digit_enable==0 for the same digit: the digit stays fully dark (dp not driven).
//  - At most one anode is low on any cycle. No anode is low during any blanking window.
//  - Reset asserted mid-slot: on the next edge, outputs return to reset values and the scan restarts
//    at index 0. A fresh snapshot loads on the first cycle after reset deasserts.
// CONFIGURATION
//  SEVENSEG_DIM_EN defined:
//    ON_TICKS = ((brightness+1)*(SLOT_TICKS+1))>>3.
//    Digit is lit only while BLANK_TICKS <= timer < ON_TICKS; otherwise all-off.
//    brightness is sampled with the snapshot (constant within a frame).
//    brightness=7 equals the undimmed behaviour.
//  SEVENSEG_DIM_EN undefined: brightness is ignored. Digit is lit for BLANK_TICKS <= timer <= SLOT_TICKS.
// STRUCTURE
//  sevenseg_pkg: NUM_DIGITS=8, SEG_OFF=7'h7F, ANODE_OFF=8'hFF, 16-entry active-low hex-to-segment table.
//  Sub-module hex_to_7seg: combinational 4-bit -> 7-bit active-low decode using the package table.
//  This module holds the slot timer, index counter, snapshot regs and output regs.
// TESTING (FREQ_HZ=800, DIGIT_HZ=100 -> SLOT_TICKS=7; BLANK_TICKS=1)
//  1. Reset, display=32'h76543210, all enables=1 -> frame_start on first cycle after reset.
//     Slot k: anode[k]=0 for 7 of 8 cycles, seg=hex7(k). Index order 0..7, 64 cycles/frame.
//  2. Change display to 32'h00000012 mid-frame -> current frame still shows 7654..;
//     next frame (after frame_start) shows 12 in digits 1,0.
//  3. digit_enable=8'b00000111, dp_enable=8'b00010100 -> anodes 3..7 never low.
//     dp=0 only while digit 2 is lit; digit 4 dp never shows.
//  4. Nibble 4'hA..4'hF in each slot -> seg matches the A,b,C,d,E,F table; 4'h0 gives 7'b1000000.
//  5. Assert reset at timer=4, index=5 -> next cycle anode=FF, seg=7F; after release, scan restarts at index 0.
//  6. SEVENSEG_DIM_EN, brightness=3 -> ON_TICKS=4; per slot lit cycles = timer 1..3 (3 cycles).
//     brightness=0 -> ON_TICKS=1, never lit. Undefined macro -> 7 lit cycles regardless of brightness.
//  Continuous checker: $countones(~anode)<=1; no anode low when timer<BLANK_TICKS.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants and hex-to-segment table for the 7-segment scanner
package sevenseg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Active-low cathode patterns {g,f,e,d,c,b,a}, entry n decodes nibble n.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational 4-bit to active-low 7-segment decode
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Every code has a glyph; A-F are shown rather than blanked.
  assign seg = HEX7_TABLE[hex];

endmodule

// File: rtl/sevenseg_scanner.sv
// rtl/sevenseg_scanner.sv - tear-free 8-digit 7-segment scanner; optional dimming via SEVENSEG_DIM_EN
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int FREQ_HZ     = 100000000,
  parameter int DIGIT_HZ    = 800,
  parameter int BLANK_TICKS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] display,
  input  logic [7:0]  digit_enable,
  input  logic [7:0]  dp_enable,
  input  logic [2:0]  brightness,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int SLOT_TICKS = FREQ_HZ / DIGIT_HZ - 1;
  localparam int TW         = (SLOT_TICKS < 2) ? 1 : $clog2(SLOT_TICKS + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(SLOT_TICKS);
  localparam logic [31:0]   BLANK_U    = BLANK_TICKS;

  logic [TW-1:0]           timer;
  logic [2:0]              index;
  logic                    load_pending;
  logic [31:0]             frame_display;
  logic [NUM_DIGITS-1:0]   frame_en;
  logic [NUM_DIGITS-1:0]   frame_dp;

  logic                    timer_wrap;
  logic                    load;
  logic [31:0]             timer_ext;
  logic [3:0]              cur_digit;
  logic [6:0]              cur_seg;
  logic                    lit;

  assign timer_wrap = (timer == TIMER_LAST);
  assign load       = load_pending | (timer_wrap && (index == 3'd7));
  assign timer_ext  = 32'(timer);
  assign cur_digit  = frame_display[{index, 2'b00} +: 4];

`ifdef SEVENSEG_DIM_EN
  localparam logic [31:0] SLOT_LEN = SLOT_TICKS + 1;

  logic [2:0]  frame_bright;
  logic [31:0] on_ticks;

  assign on_ticks = ((32'(frame_bright) + 32'd1) * SLOT_LEN) >> 3;
  assign lit      = (timer_ext >= BLANK_U) && (timer_ext < on_ticks) && frame_en[index];

  // Brightness is frozen with the rest of the frame so the duty cycle cannot change mid-scan.
  always_ff @(posedge clk) begin
    if (reset)
      frame_bright <= 3'd0;
    else if (load)
      frame_bright <= brightness;
  end
`else
  logic unused_brightness;

  assign unused_brightness = ^brightness;
  assign lit               = (timer_ext >= BLANK_U) && frame_en[index];
`endif

  hex_to_7seg u_hex_to_7seg (
    .hex (cur_digit),
    .seg (cur_seg)
  );

  // Slot timer and digit index: index advances each time the timer wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
      index <= 3'd0;
    end else begin
      timer <= timer_wrap ? '0 : timer + TW'(1);
      if (timer_wrap)
        index <= index + 3'd1;
    end
  end

  // Frame snapshot: loads right after reset and at the end of each full scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_pending  <= 1'b1;
      frame_display <= 32'd0;
      frame_en      <= '0;
      frame_dp      <= '0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= load;
      if (load) begin
        load_pending  <= 1'b0;
        frame_display <= display;
        frame_en      <= digit_enable;
        frame_dp      <= dp_enable;
      end
    end
  end

  // Pin drive: one registered stage behind the timer/index state, dark outside the lit window.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode <= ANODE_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end else if (lit) begin
      anode <= ~(8'd1 << index);
      seg   <= cur_seg;
      dp    <= ~frame_dp[index];
    end else begin
      anode <= ANODE_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// tb/tb_sevenseg_scanner.sv - randomized self-checking bench for sevenseg_scanner (honours SEVENSEG_DIM_EN)
module tb_sevenseg_scanner;

  localparam int FREQ_HZ     = 800;
  localparam int DIGIT_HZ    = 100;
  localparam int BLANK_TICKS = 1;
  localparam int CYC         = FREQ_HZ / DIGIT_HZ;
  localparam int FRAME       = CYC * 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] display;
  logic [7:0]  digit_enable;
  logic [7:0]  dp_enable;
  logic [2:0]  brightness;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  int          m = 0;
  logic [31:0] snap_disp = '0;
  logic [7:0]  snap_en   = '0;
  logic [7:0]  snap_dp   = '0;
  logic [2:0]  snap_br   = '0;
  logic [7:0]  exp_anode;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fs;

  sevenseg_scanner #(
    .FREQ_HZ     (FREQ_HZ),
    .DIGIT_HZ    (DIGIT_HZ),
    .BLANK_TICKS (BLANK_TICKS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .display      (display),
    .digit_enable (digit_enable),
    .dp_enable    (dp_enable),
    .brightness   (brightness),
    .anode        (anode),
    .seg          (seg),
    .dp           (dp),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, m);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    string s;
    logic [6:0] r;
    case (v)
      4'h0: s = "abcdef";   4'h1: s = "bc";
      4'h2: s = "abdeg";    4'h3: s = "abcdg";
      4'h4: s = "bcfg";     4'h5: s = "acdfg";
      4'h6: s = "acdefg";   4'h7: s = "abc";
      4'h8: s = "abcdefg";  4'h9: s = "abcdfg";
      4'hA: s = "abcefg";   4'hB: s = "cdefg";
      4'hC: s = "adef";     4'hD: s = "bcdeg";
      4'hE: s = "adefg";    default: s = "aefg";
    endcase
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++)
      r[s[i] - 8'd97] = 1'b0;
    return r;
  endfunction

  // One clock: predict outputs from cycles-since-reset and the frame held in the model, then check.
  task automatic tick();
    int p, t, d, on;
    logic on_now;
    @(posedge clk);
    if (reset) begin
      m = 0;
      exp_anode = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      m++;
      p = m - 1;
      t = p % CYC;
      d = (p / CYC) % 8;
`ifdef SEVENSEG_DIM_EN
      on = ((int'(snap_br) + 1) * CYC) >> 3;
`else
      on = CYC;
`endif
      on_now = (t >= BLANK_TICKS) && (t < on) && snap_en[d];
      exp_anode = on_now ? ~(8'd1 << d) : 8'hFF;
      exp_seg   = on_now ? glyph(snap_disp[d*4 +: 4]) : 7'h7F;
      exp_dp    = on_now ? ~snap_dp[d] : 1'b1;
      exp_fs    = (m == 1) || (m % FRAME == 0);
      if (exp_fs) begin
        snap_disp = display; snap_en = digit_enable;
        snap_dp   = dp_enable; snap_br = brightness;
      end
    end
    @(negedge clk);
    check_eq("anode", 32'(anode), 32'(exp_anode));
    check_eq("seg", 32'(seg), 32'(exp_seg));
    check_eq("dp", 32'(dp), 32'(exp_dp));
    check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
    check_eq("one_anode_low", 32'($countones(~anode) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    display = 32'h76543210; digit_enable = 8'hFF; dp_enable = 8'hFF; brightness = 3'd7;
    run(3);
    reset = 1'b0;

    // Full frame of 76543210, then a mid-frame change that must wait for the next snapshot.
    run(30);
    display = 32'h00000012;
    run(110);

    // Partial enables: dp on digit 4 must never show because the digit is dark.
    digit_enable = 8'b00000111; dp_enable = 8'b00010100; display = 32'h89ABCDEF;
    run(FRAME + 10);

    // Letters in every slot and zero.
    digit_enable = 8'hFF; dp_enable = 8'h00; display = 32'hFEDCBA00;
    run(FRAME);

    // Dimming levels (ignored unless the dimming build is selected).
    brightness = 3'd3; run(FRAME);
    brightness = 3'd0; run(FRAME);
    brightness = 3'd7; run(FRAME);

    // Reset mid-slot at index 5, timer 4; scan restarts from index 0 with a fresh snapshot.
    reset = 1'b1; run(2); reset = 1'b0;
    while (m < 5 * CYC + 4) tick();
    display = 32'h13572468;
    reset = 1'b1; tick();
    reset = 1'b0;
    run(FRAME + 5);

    // Random inputs changing at random moments.
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        display      = $urandom;
        digit_enable = 8'($urandom);
        dp_enable    = 8'($urandom);
        brightness   = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
